cla2_serial_sum_ctrl: RTL and testbench

//  Sequencer that computes a WIDTH-bit sum a+b+c_in over several cycles.

---
 rtl/cla2_serial_sum_ctrl_if.sv | 38 +++
 rtl/cla2_serial_sum_ctrl.sv | 153 +++++++++++++++
 tb/tb_cla2_serial_sum_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla2_serial_sum_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cla2_serial_sum_ctrl_if
//  Purpose  : Handshake and operand/result bundle for the serial 2-bit-slice
//             carry-lookahead sum sequencer.
//  Signals  : start        request, sampled on each rising clock edge
//             a, b         WIDTH-bit operands, captured on the accepted start
//             c_in         carry-in, captured on the accepted start
//             busy         slices are being processed
//             done         one-cycle pulse, sum/c_out newly valid
//             sum, c_out   registered result, held until the next completion
//  Modports : master (operand source / result consumer), slave (sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
interface cla2_serial_sum_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface
`default_nettype wire

// File: rtl/cla2_serial_sum_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cla2_serial_sum_ctrl
//  Purpose  : Computes the WIDTH-bit unsigned sum a+b+c_in over WIDTH/2
//             cycles, one 2-bit carry-lookahead slice per cycle, chaining the
//             slice carry into the next slice. Result and carry-out are held
//             stable until the next completion.
//  Ports    : clk   rising-edge system clock
//             rst   synchronous active-high reset
//             bus   slave side of cla2_serial_sum_ctrl_if
//                   (start/a/b/c_in in, busy/done/sum/c_out out)
//  Params   : WIDTH operand width, even and >= 2
//  Revision : 1.0 - initial release
// ============================================================================
module cla2_serial_sum_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  cla2_serial_sum_ctrl_if.slave      bus
);

  localparam int c_N     = WIDTH / 2;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_carry;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_psum;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_c_out;

  logic [1:0]           w_sa;
  logic [1:0]           w_sb;
  logic [1:0]           w_g;
  logic [1:0]           w_p;
  logic                 w_c1;
  logic [1:0]           w_s;
  logic                 w_gg;
  logic                 w_pp;
  logic                 w_carry_next;
  logic [WIDTH-1:0]     w_psum_next;

  // Select the operand bits of the slice addressed by r_idx.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int k = 0; k < c_N; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_sa = r_a[2*k +: 2];
        w_sb = r_b[2*k +: 2];
      end
    end
  end

  // 2-bit carry-lookahead slice: per-bit generate/propagate, then the
  // group generate/propagate gives the slice carry without rippling.
  always_comb begin
    w_g          = w_sa & w_sb;
    w_p          = w_sa ^ w_sb;
    w_c1         = w_g[0] | (w_p[0] & r_carry);
    w_s          = {w_p[1] ^ w_c1, w_p[0] ^ r_carry};
    w_gg         = w_g[1] | (w_p[1] & w_g[0]);
    w_pp         = w_p[1] & w_p[0];
    w_carry_next = w_gg | (w_pp & r_carry);
  end

  // Partial sum with the current slice merged in; on the last slice this is
  // the complete result, so it can be published in the same edge.
  always_comb begin
    w_psum_next = r_psum;
    for (int k = 0; k < c_N; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_psum_next[2*k +: 2] = w_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back
        // operation without an idle gap.
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.c_in;
            r_idx   <= '0;
            r_psum  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        // start is ignored here; operands were frozen at acceptance.
        ST_RUN: begin
          r_psum  <= w_psum_next;
          r_carry <= w_carry_next;
          if (r_idx == c_IDX_LAST) begin
            r_sum   <= w_psum_next;
            r_c_out <= w_carry_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + c_IDX_W'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_cla2_serial_sum_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cla2_serial_sum_ctrl
//  Purpose  : Self-checking bench for cla2_serial_sum_ctrl (WIDTH=8 and
//             WIDTH=2 instances). A cycle-level behavioural model predicts
//             busy/done/sum/c_out from plain arithmetic; literal expectations
//             pin the model on directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla2_serial_sum_ctrl;

  localparam int N8 = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla2_serial_sum_ctrl_if #(.WIDTH(8)) bus8 ();
  cla2_serial_sum_ctrl_if #(.WIDTH(2)) bus2 ();

  cla2_serial_sum_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  cla2_serial_sum_ctrl #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (WIDTH=8 instance) ----------------
  int         m_cnt   = 0;   // slice edges still to go for the operation in flight
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic [7:0] m_sum   = 8'h00;
  logic       m_cout  = 1'b0;
  logic [8:0] m_pend  = 9'h000;
  int         m_acc   = 0;
  int         m_fin   = 0;
  int         dut_done_cnt = 0;
  bit         chk_en  = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_sum  = 8'h00;
      m_cout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          {m_cout, m_sum} = m_pend;
          m_fin++;
        end
      end else if (bus8.start) begin
        m_pend = {1'b0, bus8.a} + {1'b0, bus8.b} + 9'(bus8.c_in);
        m_cnt  = N8;
        m_acc++;
      end
      m_busy = (m_cnt > 0);
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy",  32'(bus8.busy),  32'(m_busy));
      chk("done",  32'(bus8.done),  32'(m_done));
      chk("sum",   32'(bus8.sum),   32'(m_sum));
      chk("c_out", 32'(bus8.c_out), 32'(m_cout));
      chk("busy_and_done", 32'(bus8.busy & bus8.done), 32'd0);
      if (bus8.done) dut_done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = c;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = ~a;      // operands must not matter after acceptance
    bus8.b     = ~b;
    bus8.c_in  = ~c;
  endtask

  // Returns at the negedge where done is seen (or after max cycles).
  task automatic wait_done(input int max, output int busy_cycles, output logic ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus8.done) begin
        ok = 1'b1;
        break;
      end
      if (bus8.busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'hAA};
  logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h55};
  logic       vc [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] vs [3] = '{8'h10, 8'h00, 8'h00};
  logic       vo [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int   bc;
    logic ok;
    int   seen;
    int   acc0, done0, cycles;

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.c_in = 1'b0;
    bus2.start = 1'b0; bus2.a = 2'b00; bus2.b = 2'b00; bus2.c_in = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, both instances
    chk("rst_busy8",  32'(bus8.busy),  32'd0);
    chk("rst_done8",  32'(bus8.done),  32'd0);
    chk("rst_sum8",   32'(bus8.sum),   32'd0);
    chk("rst_cout8",  32'(bus8.c_out), 32'd0);
    chk("rst_busy2",  32'(bus2.busy),  32'd0);
    chk("rst_sum2",   32'(bus2.sum),   32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: 0x0F+0x01, 0xFF+0x01 (full ripple), 0xAA+0x55+1
    for (int t = 0; t < 3; t++) begin
      start_op(va[t], vb[t], vc[t]);
      wait_done(12, bc, ok);
      chk($sformatf("vec%0d_done_seen", t), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_busy_cycles", t), 32'(bc), 32'd4);
      chk($sformatf("vec%0d_sum", t), 32'(bus8.sum), 32'(vs[t]));
      chk($sformatf("vec%0d_cout", t), 32'(bus8.c_out), 32'(vo[t]));
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", t), 32'(bus8.done), 32'd0);
    end

    // WIDTH=2: 2'b10 + 2'b11 -> sum 2'b01, c_out 1; RUN lasts one cycle
    bus2.start = 1'b1; bus2.a = 2'b10; bus2.b = 2'b11; bus2.c_in = 1'b0;
    @(negedge clk);
    bus2.start = 1'b0; bus2.a = 2'b00; bus2.b = 2'b00;
    chk("w2_busy", 32'(bus2.busy), 32'd1);
    chk("w2_done_early", 32'(bus2.done), 32'd0);
    @(negedge clk);
    chk("w2_done", 32'(bus2.done), 32'd1);
    chk("w2_busy_in_done", 32'(bus2.busy), 32'd0);
    chk("w2_sum", 32'(bus2.sum), 32'd1);
    chk("w2_cout", 32'(bus2.c_out), 32'd1);
    @(negedge clk);
    chk("w2_done_pulse", 32'(bus2.done), 32'd0);

    // Start held high through RUN with new operands: re-accepted in DONE
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.c_in = 1'b0;
    @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF;
    wait_done(12, bc, ok);
    chk("hold_first_done", 32'(ok), 32'd1);
    chk("hold_first_sum", 32'(bus8.sum), 32'h02);
    chk("hold_first_cout", 32'(bus8.c_out), 32'd0);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done(12, bc, ok);
    chk("hold_second_done", 32'(ok), 32'd1);
    chk("hold_second_busy_cycles", 32'(bc), 32'd4);
    chk("hold_second_sum", 32'(bus8.sum), 32'hFE);
    chk("hold_second_cout", 32'(bus8.c_out), 32'd1);
    @(negedge clk);

    // Reset in mid-RUN aborts without a done pulse
    start_op(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_sum",  32'(bus8.sum),  32'd0);
    chk("abort_cout", 32'(bus8.c_out), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus8.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(12, bc, ok);
    chk("after_abort_done", 32'(ok), 32'd1);
    chk("after_abort_sum", 32'(bus8.sum), 32'h46);
    chk("after_abort_cout", 32'(bus8.c_out), 32'd0);
    @(negedge clk);

    // 1000 back-to-back random operations, checked by the model every cycle
    acc0   = m_acc;
    done0  = dut_done_cnt;
    cycles = 0;
    bus8.start = 1'b1;
    while ((m_acc - acc0) < 1000 && cycles < 20000) begin
      bus8.a    = 8'($urandom);
      bus8.b    = 8'($urandom);
      bus8.c_in = 1'($urandom);
      @(negedge clk);
      cycles++;
    end
    bus8.start = 1'b0;
    chk("rand_starts", 32'(m_acc - acc0), 32'd1000);
    repeat (8) @(negedge clk);
    chk("rand_done_count", 32'(dut_done_cnt - done0), 32'd1000);
    chk("rand_idle_busy", 32'(bus8.busy), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
